// File: rtl/unary_add_seq.sv
`timescale 1ns/1ps
// Multi-digit base-9 adder built on one shared 1-digit unary adder core.
// Digits go LSB first: operands stream in as pulses, then the core drains and its pulses are counted.
module unary_add_seq #(
    parameter int DIGITS    = 4,
    parameter int WR_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   op_a,
    input  logic [4*DIGITS-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry_out,
    output logic                  core_A,
    output logic                  core_B,
    output logic                  core_en,
    output logic                  core_rw,
    input  logic                  core_dout,
    input  logic                  core_C
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam int WW = $clog2(WR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_READ, S_SETTLE, S_WRITE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      k_q, k_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            cin_q, cin_d;
    logic            cacc_q, cacc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_out_q, carry_out_d;
    logic            err_q, err_d;

    function automatic logic [3:0] digit_at(input logic [W-1:0] v, input logic [IW-1:0] i);
        logic [3:0] d;
        d = 4'd0;
        for (int j = 0; j < DIGITS; j++) begin
            if (i == IW'(j)) d = v[4*j +: 4];
        end
        return d;
    endfunction

    function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [3:0]    dig_a, dig_b, mx_cur, r_cur;
    logic [IW-1:0] idx_nxt;
    logic [3:0]    r_nxt, r_first;
    logic [3:0]    cnt_nxt;
    logic          bad_digit;

    always_comb begin
        dig_a   = digit_at(op_a_q, idx_q);
        dig_b   = digit_at(op_b_q, idx_q);
        mx_cur  = max4(dig_a, dig_b);
        r_cur   = mx_cur + {3'd0, cin_q};
        idx_nxt = idx_q + IW'(1);
        // Read length of the following digit, with the carry this digit is producing.
        r_nxt   = max4(digit_at(op_a_q, idx_nxt), digit_at(op_b_q, idx_nxt)) + {3'd0, cacc_q};
        r_first = max4(digit_at(op_a_q, '0), digit_at(op_b_q, '0));
        cnt_nxt = cnt_q + {3'd0, (wcnt_q != '0) & core_dout};
        bad_digit = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (op_a_q[4*j +: 4] > 4'd8 || op_b_q[4*j +: 4] > 4'd8) bad_digit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        idx_d       = idx_q;
        k_d         = k_q;
        wcnt_d      = wcnt_q;
        cnt_d       = cnt_q;
        cin_d       = cin_q;
        cacc_d      = cacc_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        err_d       = err_q;
        core_A      = 1'b0;
        core_B      = 1'b0;
        core_en     = 1'b0;
        core_rw     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d      = op_a;
                    op_b_d      = op_b;
                    sum_d       = '0;
                    err_d       = 1'b0;
                    carry_out_d = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_digit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cin_d   = 1'b0;
                    idx_d   = '0;
                    k_d     = '0;
                    cacc_d  = 1'b0;
                    state_d = (r_first == 4'd0) ? S_SETTLE : S_READ;
                end
            end
            S_READ: begin
                core_en = 1'b1;
                // The trailing carry-in pulse lands on cycle k == max(a,b).
                core_A  = (k_q < dig_a) | (cin_q & (k_q == mx_cur));
                core_B  = (k_q < dig_b);
                if (k_q != 4'd0) cacc_d = cacc_q | core_C;
                if (k_q == r_cur - 4'd1) begin
                    state_d = S_SETTLE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_SETTLE: begin
                core_en = 1'b1;
                cacc_d  = cacc_q | core_C;
                wcnt_d  = '0;
                cnt_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                core_en = 1'b1;
                core_rw = 1'b1;
                cnt_d   = cnt_nxt;
                wcnt_d  = wcnt_q + WW'(1);
                if (wcnt_q == WW'(WR_CYCLES - 1)) begin
                    for (int j = 0; j < DIGITS; j++) begin
                        if (idx_q == IW'(j)) sum_d[4*j +: 4] = cnt_nxt;
                    end
                    cin_d  = cacc_q;
                    idx_d  = idx_nxt;
                    k_d    = '0;
                    cacc_d = 1'b0;
                    if (idx_nxt == IW'(DIGITS)) begin
                        carry_out_d = cacc_q;
                        state_d     = S_DONE;
                    end else begin
                        state_d = (r_nxt == 4'd0) ? S_SETTLE : S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            cin_q       <= 1'b0;
            cacc_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            cin_q       <= cin_d;
            cacc_q      <= cacc_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_unary_add_seq.sv
`timescale 1ns/1ps
// Directed bench for unary_add_seq with a behavioural 1-digit unary adder core attached.
module tb_unary_add_seq;
    localparam int DIGITS    = 4;
    localparam int WR_CYCLES = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, done, err, carry_out;
    logic [15:0] sum;
    logic        core_A, core_B, core_en, core_rw;
    logic        core_dout, core_C;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unary_add_seq #(.DIGITS(DIGITS), .WR_CYCLES(WR_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .err(err), .sum(sum), .carry_out(carry_out),
        .core_A(core_A), .core_B(core_B), .core_en(core_en), .core_rw(core_rw),
        .core_dout(core_dout), .core_C(core_C)
    );

    // Core: count 0..8, C flags a wrap one cycle later, write mode emits one dout pulse per unit.
    logic [3:0] core_cnt;
    logic [4:0] core_tmp;
    assign core_tmp = {1'b0, core_cnt} + {4'd0, core_A} + {4'd0, core_B};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt  <= '0;
            core_C    <= 1'b0;
            core_dout <= 1'b0;
        end else if (core_en && !core_rw) begin
            core_dout <= 1'b0;
            if (core_tmp >= 5'd9) begin
                core_cnt <= 4'(core_tmp - 5'd9);
                core_C   <= 1'b1;
            end else begin
                core_cnt <= core_tmp[3:0];
                core_C   <= 1'b0;
            end
        end else if (core_en && core_rw) begin
            core_C <= 1'b0;
            if (core_cnt != 4'd0) begin
                core_dout <= 1'b1;
                core_cnt  <= core_cnt - 4'd1;
            end else begin
                core_dout <= 1'b0;
            end
        end else begin
            core_C    <= 1'b0;
            core_dout <= 1'b0;
        end
    end

    int c_pulses = 0, en_cycles = 0, done_pulses = 0;
    always @(negedge clk) begin
        if (core_C)  c_pulses    <= c_pulses + 1;
        if (core_en) en_cycles   <= en_cycles + 1;
        if (done)    done_pulses <= done_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_sum, input logic exp_co, input logic exp_err,
                          input int exp_lat, input int poke,
                          output int c_delta, output int en_delta);
        int lat;
        bit seen;
        int c0, e0;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        c0 = c_pulses; e0 = en_cycles;
        @(posedge clk);
        lat = 0; seen = 0;
        while (lat < 400 && !seen) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
            if (lat == poke) begin
                op_a = 16'h1111; op_b = 16'h1111;
            end
            if (lat == 1) chk({tag, "_busy_first"}, busy, 1'b1);
            if (done) seen = 1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_carry_out"}, carry_out, exp_co);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_sum_held"}, sum, exp_sum);
        c_delta  = c_pulses - c0;
        en_delta = en_cycles - e0;
    endtask

    initial begin
        int cd, ed, dp0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_carry", carry_out, 1'b0);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_core_rw", core_rw, 1'b0);
        chk("rst_core_ab", {core_A, core_B}, 2'b00);
        rst_n = 1'b1;

        run_op("add_8_1", 16'h0008, 16'h0001, 16'h0010, 1'b0, 1'b0, 55, 0, cd, ed);
        chk("add_8_1_cpulses", cd, 1);

        run_op("add_8888", 16'h8888, 16'h8888, 16'h8887, 1'b1, 1'b0, 81, 0, cd, ed);
        chk("add_8888_cpulses", cd, 4);

        run_op("add_zero", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 46, 0, cd, ed);
        chk("add_zero_en_cycles", ed, 4 * (1 + WR_CYCLES));

        run_op("add_mixed", 16'h1234, 16'h5678, 16'h7023, 1'b0, 1'b0, 75, 0, cd, ed);
        chk("add_mixed_cpulses", cd, 3);

        run_op("err_lsd", 16'h0009, 16'h0000, 16'h0000, 1'b0, 1'b1, 2, 0, cd, ed);
        chk("err_lsd_core_en", ed, 0);

        run_op("err_msd", 16'h0000, 16'h9000, 16'h0000, 1'b0, 1'b1, 2, 0, cd, ed);
        chk("err_msd_core_en", ed, 0);

        // A second start while busy must not launch a queued operation.
        run_op("poke", 16'h0008, 16'h0001, 16'h0010, 1'b0, 1'b0, 55, 10, cd, ed);
        dp0 = done_pulses;
        repeat (80) @(negedge clk);
        chk("poke_no_second_done", done_pulses - dp0, 0);
        chk("poke_idle_busy", busy, 1'b0);
        chk("poke_sum_still", sum, 16'h0010);

        // Reset during digit 1 WRITE (cycles 20..29 after the start edge).
        @(negedge clk);
        op_a = 16'h0024; op_b = 16'h0013; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        chk("mid_core_rw", core_rw, 1'b1);
        chk("mid_partial_sum", sum, 16'h0007);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_sum", sum, 16'h0000);
        chk("mid_rst_core_en", core_en, 1'b0);
        chk("mid_rst_carry", carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post_rst", 16'h0103, 16'h0806, 16'h1010, 1'b0, 1'b0, 62, 0, cd, ed);
        chk("post_rst_cpulses", cd, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
